// File: rtl/pipe_fwd_ctrl.sv
// Forwarding and load-use hazard controller: tracks DEPTH in-flight writes after EX,
// forwards the youngest match to the operand buses and drives write-back from the last stage.
module pipe_fwd_ctrl #(
    parameter int XLEN       = 32,
    parameter int REGW       = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 1,
    parameter int CNTW       = 16
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [REGW-1:0] rs1,
    input  logic [REGW-1:0] rs2,
    input  logic [XLEN-1:0] rf_busA,
    input  logic [XLEN-1:0] rf_busB,
    input  logic            ex_valid,
    input  logic [REGW-1:0] ex_rd,
    input  logic            ex_regwr,
    input  logic            ex_memtoreg,
    input  logic [XLEN-1:0] ex_result,
    input  logic            flush,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] fwd_busA,
    output logic [XLEN-1:0] fwd_busB,
    output logic            stall,
    output logic [REGW-1:0] wb_rd,
    output logic            wb_regwr,
    output logic [XLEN-1:0] wb_data,
    output logic [CNTW-1:0] stall_cnt
);

    logic [DEPTH:1]           st_v;
    logic [DEPTH:1][REGW-1:0] st_rd;
    logic [DEPTH:1]           st_regwr;
    logic [DEPTH:1]           st_mem;
    logic [DEPTH:1][XLEN-1:0] st_data;

    logic [DEPTH:1][XLEN-1:0] eff_data;
    logic [DEPTH:1]           eff_rdy;

    logic                     ex_live;
    logic [1:0][REGW-1:0]     rs_op;
    logic [1:0][XLEN-1:0]     rf_op;
    logic [1:0][XLEN-1:0]     fwd_op;
    logic [1:0]               rdy_op;
    logic [1:0]               hit_op;

    assign ex_live = ex_valid & ~flush;
    assign rs_op   = {rs2, rs1};
    assign rf_op   = {rf_busB, rf_busA};

    // A load is unresolved before LOAD_STAGE and reads the live memory bus at LOAD_STAGE.
    always_comb begin
        eff_data = st_data;
        eff_rdy  = '1;
        for (int s = 1; s <= DEPTH; s++) begin
            if (st_mem[s]) begin
                if (s < LOAD_STAGE)
                    eff_rdy[s] = 1'b0;
                else if (s == LOAD_STAGE)
                    eff_data[s] = mem_rdata;
            end
        end
    end

    always_comb begin
        fwd_op = rf_op;
        rdy_op = '1;
        hit_op = '0;
        for (int op = 0; op < 2; op++) begin
            if (rs_op[op] == '0) begin
                fwd_op[op] = '0;
            end else begin
                if (ex_live && ex_regwr && ex_rd == rs_op[op]) begin
                    hit_op[op] = 1'b1;
                    fwd_op[op] = ex_result;
                    rdy_op[op] = ~ex_memtoreg;
                end
                for (int s = 1; s <= DEPTH; s++) begin
                    if (!hit_op[op] && st_v[s] && st_regwr[s] && st_rd[s] == rs_op[op]) begin
                        hit_op[op] = 1'b1;
                        fwd_op[op] = eff_data[s];
                        rdy_op[op] = eff_rdy[s];
                    end
                end
            end
        end
    end

    assign fwd_busA = fwd_op[0];
    assign fwd_busB = fwd_op[1];
    assign stall    = ~rdy_op[0] | ~rdy_op[1];

    assign wb_rd    = st_rd[DEPTH];
    assign wb_regwr = st_v[DEPTH] & st_regwr[DEPTH] & (st_rd[DEPTH] != '0);
    assign wb_data  = eff_data[DEPTH];

    always_ff @(posedge clock) begin
        if (!reset) begin
            st_v      <= '0;
            stall_cnt <= '0;
        end else begin
            st_v[1]     <= ex_live & ~stall;
            st_rd[1]    <= ex_rd;
            st_regwr[1] <= ex_regwr;
            st_mem[1]   <= ex_memtoreg;
            st_data[1]  <= ex_result;
            for (int s = 2; s <= DEPTH; s++) begin
                st_v[s]     <= st_v[s-1];
                st_rd[s]    <= st_rd[s-1];
                st_regwr[s] <= st_regwr[s-1];
                st_mem[s]   <= st_mem[s-1];
                // Load data is captured as the entry leaves LOAD_STAGE.
                if ((s - 1) == LOAD_STAGE && st_mem[s-1])
                    st_data[s] <= mem_rdata;
                else
                    st_data[s] <= st_data[s-1];
            end
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNTW'(1);
        end
    end

endmodule

// File: tb/tb_pipe_fwd_ctrl.sv
// Directed bench for pipe_fwd_ctrl: a DEPTH=3/LOAD_STAGE=1 instance and a
// DEPTH=2/LOAD_STAGE=2/CNTW=4 instance share the same stimulus.
module tb_pipe_fwd_ctrl;

    logic        clock;
    logic        reset;
    logic [4:0]  rs1, rs2;
    logic [31:0] rf_busA, rf_busB;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic        ex_regwr, ex_memtoreg;
    logic [31:0] ex_result;
    logic        flush;
    logic [31:0] mem_rdata;

    logic [31:0] fwd_busA, fwd_busB, wb_data;
    logic        stall, wb_regwr;
    logic [4:0]  wb_rd;
    logic [15:0] stall_cnt;

    logic [31:0] fwd_busA_2, fwd_busB_2, wb_data_2;
    logic        stall_2, wb_regwr_2;
    logic [4:0]  wb_rd_2;
    logic [3:0]  stall_cnt_2;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_fwd_ctrl #(.XLEN(32), .REGW(5), .DEPTH(3), .LOAD_STAGE(1), .CNTW(16)) dut (
        .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2),
        .rf_busA(rf_busA), .rf_busB(rf_busB),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwr(ex_regwr),
        .ex_memtoreg(ex_memtoreg), .ex_result(ex_result), .flush(flush),
        .mem_rdata(mem_rdata),
        .fwd_busA(fwd_busA), .fwd_busB(fwd_busB), .stall(stall),
        .wb_rd(wb_rd), .wb_regwr(wb_regwr), .wb_data(wb_data), .stall_cnt(stall_cnt)
    );

    pipe_fwd_ctrl #(.XLEN(32), .REGW(5), .DEPTH(2), .LOAD_STAGE(2), .CNTW(4)) dut_2 (
        .clock(clock), .reset(reset), .rs1(rs1), .rs2(rs2),
        .rf_busA(rf_busA), .rf_busB(rf_busB),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwr(ex_regwr),
        .ex_memtoreg(ex_memtoreg), .ex_result(ex_result), .flush(flush),
        .mem_rdata(mem_rdata),
        .fwd_busA(fwd_busA_2), .fwd_busB(fwd_busB_2), .stall(stall_2),
        .wb_rd(wb_rd_2), .wb_regwr(wb_regwr_2), .wb_data(wb_data_2), .stall_cnt(stall_cnt_2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ex_idle();
        ex_valid    = 1'b0;
        ex_rd       = 5'd0;
        ex_regwr    = 1'b0;
        ex_memtoreg = 1'b0;
        ex_result   = 32'h0;
        flush       = 1'b0;
    endtask

    task automatic ex_drive(input logic [4:0] rd, input logic [31:0] data, input logic load);
        ex_valid    = 1'b1;
        ex_rd       = rd;
        ex_regwr    = 1'b1;
        ex_memtoreg = load;
        ex_result   = data;
        flush       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ex_idle();
        rs1 = 5'd0; rs2 = 5'd0;
        rf_busA = 32'hA0A0_0000; rf_busB = 32'hB0B0_0000;
        mem_rdata = 32'h0;
        tick(); tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (wb_regwr !== 1'b0) begin n_fail++; $display("FAIL reset_wb_regwr: got %b expected 0", wb_regwr); end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
        n_checks++;
        if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
        n_checks++;
        if (stall_cnt_2 !== 4'd0) begin n_fail++; $display("FAIL reset_stall_cnt_2: got %0d expected 0", stall_cnt_2); end
    endtask

    task automatic test_alu_back_to_back();
        ex_drive(5'd5, 32'h11, 1'b0);
        rs1 = 5'd5;
        #1;
        n_checks++;
        if (fwd_busA !== 32'h11) begin n_fail++; $display("FAIL alu_ex_fwd: got %h expected 00000011", fwd_busA); end
        n_checks++;
        if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_ex_stall: got %b expected 0", stall); end
        tick();
        ex_idle();
        #1;
        n_checks++;
        if (fwd_busA !== 32'h11) begin n_fail++; $display("FAIL alu_stage1_fwd: got %h expected 00000011", fwd_busA); end
        n_checks++;
        if (wb_regwr !== 1'b0) begin n_fail++; $display("FAIL alu_early_wb: got %b expected 0", wb_regwr); end
        tick(); tick();
        n_checks++;
        if (wb_regwr !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h11) begin
            n_fail++;
            $display("FAIL alu_wb: got regwr=%b rd=%0d data=%h expected regwr=1 rd=5 data=00000011", wb_regwr, wb_rd, wb_data);
        end
        n_checks++;
        if (fwd_busA !== 32'h11) begin n_fail++; $display("FAIL alu_stage3_fwd: got %h expected 00000011", fwd_busA); end
        tick();
        n_checks++;
        if (wb_regwr !== 1'b0) begin n_fail++; $display("FAIL alu_wb_done: got %b expected 0", wb_regwr); end
        n_checks++;
        if (fwd_busA !== 32'hA0A0_0000) begin n_fail++; $display("FAIL alu_retired_fwd: got %h expected a0a00000", fwd_busA); end
        rs1 = 5'd0;
    endtask

    task automatic test_priority();
        ex_drive(5'd7, 32'hAA, 1'b0);
        tick();
        ex_drive(5'd7, 32'hBB, 1'b0);
        tick();
        ex_idle();
        rs2 = 5'd7;
        #1;
        n_checks++;
        if (fwd_busB !== 32'hBB) begin n_fail++; $display("FAIL prio_stage1: got %h expected 000000bb", fwd_busB); end
        ex_drive(5'd7, 32'hCC, 1'b0);
        #1;
        n_checks++;
        if (fwd_busB !== 32'hCC) begin n_fail++; $display("FAIL prio_ex: got %h expected 000000cc", fwd_busB); end
        ex_idle();
        tick();
        n_checks++;
        if (fwd_busB !== 32'hBB) begin n_fail++; $display("FAIL prio_stage2: got %h expected 000000bb", fwd_busB); end
        rs2 = 5'd0;
        tick(); tick();
    endtask

    task automatic test_x0_flush();
        ex_drive(5'd0, 32'h55, 1'b0);
        rs1 = 5'd0;
        #1;
        n_checks++;
        if (fwd_busA !== 32'h0) begin n_fail++; $display("FAIL x0_fwd: got %h expected 00000000", fwd_busA); end
        tick();
        ex_idle();
        tick(); tick();
        n_checks++;
        if (wb_regwr !== 1'b0 || wb_rd !== 5'd0) begin
            n_fail++;
            $display("FAIL x0_wb: got regwr=%b rd=%0d expected regwr=0 rd=0", wb_regwr, wb_rd);
        end
        ex_drive(5'd9, 32'h99, 1'b0);
        flush = 1'b1;
        rs2 = 5'd9;
        #1;
        n_checks++;
        if (fwd_busB !== 32'hB0B0_0000) begin n_fail++; $display("FAIL flush_ex_fwd: got %h expected b0b00000", fwd_busB); end
        tick();
        ex_idle();
        #1;
        n_checks++;
        if (fwd_busB !== 32'hB0B0_0000) begin n_fail++; $display("FAIL flush_stage1: got %h expected b0b00000", fwd_busB); end
        rs2 = 5'd0;
        tick(); tick();
    endtask

    task automatic test_load_use();
        ex_drive(5'd3, 32'hDEAD, 1'b1);
        rs1 = 5'd3;
        #1;
        n_checks++;
        if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_ex_stall: got %b expected 1", stall); end
        tick();
        ex_idle();
        #1;
        n_checks++;
        if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt); end
        n_checks++;
        if (stall !== 1'b0 || fwd_busA !== 32'hA0A0_0000) begin
            n_fail++;
            $display("FAIL lu_bubble: got stall=%b fwd=%h expected stall=0 fwd=a0a00000", stall, fwd_busA);
        end
        // load accepted with no dependent reader, then consumed from the stages
        rs1 = 5'd0;
        ex_drive(5'd3, 32'hDEAD, 1'b1);
        tick();
        ex_idle();
        rs1 = 5'd3;
        mem_rdata = 32'h1234;
        #1;
        n_checks++;
        if (stall !== 1'b0 || fwd_busA !== 32'h1234) begin
            n_fail++;
            $display("FAIL lu_stage1_fwd: got stall=%b fwd=%h expected stall=0 fwd=00001234", stall, fwd_busA);
        end
        n_checks++;
        if (stall_2 !== 1'b1) begin n_fail++; $display("FAIL lu2_not_ready: got %b expected 1", stall_2); end
        tick();
        mem_rdata = 32'h5678;
        #1;
        n_checks++;
        if (stall !== 1'b0 || fwd_busA !== 32'h1234) begin
            n_fail++;
            $display("FAIL lu_captured: got stall=%b fwd=%h expected stall=0 fwd=00001234", stall, fwd_busA);
        end
        n_checks++;
        if (stall_2 !== 1'b0 || fwd_busA_2 !== 32'h5678) begin
            n_fail++;
            $display("FAIL lu2_fwd: got stall=%b fwd=%h expected stall=0 fwd=00005678", stall_2, fwd_busA_2);
        end
        n_checks++;
        if (wb_regwr_2 !== 1'b1 || wb_rd_2 !== 5'd3 || wb_data_2 !== 32'h5678) begin
            n_fail++;
            $display("FAIL lu2_wb: got regwr=%b rd=%0d data=%h expected regwr=1 rd=3 data=00005678", wb_regwr_2, wb_rd_2, wb_data_2);
        end
        tick();
        n_checks++;
        if (wb_regwr !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'h1234) begin
            n_fail++;
            $display("FAIL lu_wb: got regwr=%b rd=%0d data=%h expected regwr=1 rd=3 data=00001234", wb_regwr, wb_rd, wb_data);
        end
        n_checks++;
        if (stall_cnt !== 16'd1) begin n_fail++; $display("FAIL lu_cnt_hold: got %0d expected 1", stall_cnt); end
        rs1 = 5'd0;
        mem_rdata = 32'h0;
        tick();
    endtask

    task automatic test_reset_mid();
        ex_drive(5'd1, 32'h101, 1'b0);
        tick();
        ex_drive(5'd2, 32'h202, 1'b0);
        tick();
        ex_drive(5'd3, 32'h303, 1'b0);
        tick();
        ex_idle();
        #1;
        n_checks++;
        if (wb_regwr !== 1'b1 || wb_rd !== 5'd1) begin
            n_fail++;
            $display("FAIL mid_pre_wb: got regwr=%b rd=%0d expected regwr=1 rd=1", wb_regwr, wb_rd);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        rs1 = 5'd2;
        rs2 = 5'd3;
        #1;
        n_checks++;
        if (wb_regwr !== 1'b0) begin n_fail++; $display("FAIL mid_wb: got %b expected 0", wb_regwr); end
        n_checks++;
        if (stall_cnt !== 16'd0 || stall_cnt_2 !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_cnt: got %0d/%0d expected 0/0", stall_cnt, stall_cnt_2);
        end
        n_checks++;
        if (fwd_busA !== 32'hA0A0_0000 || fwd_busB !== 32'hB0B0_0000) begin
            n_fail++;
            $display("FAIL mid_fwd: got %h/%h expected a0a00000/b0b00000", fwd_busA, fwd_busB);
        end
        tick();
        n_checks++;
        if (wb_regwr !== 1'b0) begin n_fail++; $display("FAIL mid_wb_later: got %b expected 0", wb_regwr); end
        rs1 = 5'd0;
        rs2 = 5'd0;
    endtask

    task automatic test_saturation();
        ex_drive(5'd6, 32'h66, 1'b1);
        rs1 = 5'd6;
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (stall_cnt_2 !== 4'd10) begin n_fail++; $display("FAIL sat_mid: got %0d expected 10", stall_cnt_2); end
        for (int i = 0; i < 10; i++) tick();
        n_checks++;
        if (stall_cnt_2 !== 4'd15) begin n_fail++; $display("FAIL sat_cnt4: got %0d expected 15", stall_cnt_2); end
        n_checks++;
        if (stall_cnt !== 16'd20) begin n_fail++; $display("FAIL sat_cnt16: got %0d expected 20", stall_cnt); end
        n_checks++;
        if (stall !== 1'b1 || wb_regwr !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_hold: got stall=%b wb_regwr=%b expected stall=1 wb_regwr=0", stall, wb_regwr);
        end
        ex_idle();
        rs1 = 5'd0;
        tick();
    endtask

    initial begin
        test_reset();
        test_alu_back_to_back();
        test_priority();
        test_x0_flush();
        test_load_use();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
